// File: rtl/slow_mem_responder.sv
// slow_mem_responder: fixed-latency line-wide memory model answering cache read/write requests with a one-cycle ready pulse
module slow_mem_responder #(
  parameter int LATENCY = 8,
  parameter int IDX_W = 10
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count,
  output logic         protocol_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [7:0] LAT = 8'(LATENCY);
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [27:0] addr_q;
  logic [127:0] wdata_q;
  logic wr_q;
  logic req, viol;
  logic [IDX_W-1:0] idx_q;
  logic [127:0] mem [2**IDX_W];
  assign req = mem_read | mem_write;
  assign idx_q = addr_q[IDX_W+3:4];
  assign mem_ready = state == RESP;
  assign mem_rdata = (state == RESP && !wr_q) ? mem[idx_q] : '0;
  // a conflicting read+write at acceptance, or any drift of a held request while waiting, is a violation
  assign viol = (state == IDLE && mem_read && mem_write) ||
                (state == WAIT && req && (mem_addr != addr_q || mem_write != wr_q || (wr_q && mem_wdata != wdata_q)));
  // next-state: WAIT spans LATENCY-1 cycles so ready lands exactly LATENCY cycles after the request first appears
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (req) begin
        state_nx = (LAT == 8'd1) ? RESP : WAIT;
        cnt_nx = LAT - 8'd1;
      end
      WAIT: if (!req) state_nx = IDLE;
        else begin
          cnt_nx = cnt - 8'd1;
          state_nx = (cnt == 8'd1) ? RESP : WAIT;
        end
      default: state_nx = IDLE;
    endcase
  end
  // state, request latches, counters and sticky error
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      cnt <= '0;
      rd_count <= '0;
      wr_count <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (state == IDLE && req) begin
        addr_q <= mem_addr;
        wdata_q <= mem_wdata;
        wr_q <= mem_write;
      end
      if (viol) protocol_err <= 1'b1;
      if (state == RESP && wr_q) wr_count <= wr_count + 32'd1;
      if (state == RESP && !wr_q) rd_count <= rd_count + 32'd1;
    end
  end
  // storage survives reset; a write commits only at the edge ending its response cycle
  always_ff @(posedge clk) begin
    if (!proc_reset && state == RESP && wr_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: directed tests of latency, storage, back-to-back, abort, protocol error and reset
module tb_slow_mem_responder;
  logic clk = 0, proc_reset = 1, mem_read = 0, mem_write = 0;
  logic [27:0] mem_addr = 0;
  logic [127:0] mem_wdata = 0;
  logic [127:0] rdata0, rdata1;
  logic ready0, ready1, err0, err1;
  logic [31:0] rdc0, rdc1, wrc0, wrc1;
  int total = 0, bad = 0, cyc = 0;
  localparam logic [127:0] D_BEEF = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] E3 = 128'h33333333_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] E7 = 128'h77777777_8888_9999_AAAA_BBBB_CCCC_DDDD;
  localparam logic [127:0] VA = 128'hA5A5A5A5_5A5A5A5A_01234567_89ABCDEF;
  localparam logic [127:0] VB = 128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE;
  localparam logic [127:0] VF = 128'hF0F0F0F0_0F0F0F0F_12121212_34343434;
  localparam logic [127:0] VG = 128'h600D600D_600D600D_600D600D_600D600D;

  slow_mem_responder #(.LATENCY(8), .IDX_W(10)) u0 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata0), .mem_ready(ready0),
    .rd_count(rdc0), .wr_count(wrc0), .protocol_err(err0));
  slow_mem_responder #(.LATENCY(1), .IDX_W(10)) u1 (
    .clk(clk), .proc_reset(proc_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(rdata1), .mem_ready(ready1),
    .rd_count(rdc1), .wr_count(wrc1), .protocol_err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy(input bit s);
    return s ? ready1 : ready0;
  endfunction
  function automatic logic [127:0] rdat(input bit s);
    return s ? rdata1 : rdata0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1;
    step();
    proc_reset = 0;
  endtask

  task automatic do_req(input bit s, input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, input int drop_k, input int chg_k,
                        output int lat, output logic [127:0] data, output int nz);
    lat = -1;
    data = '0;
    nz = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) begin
        mem_read = rd;
        mem_write = wr;
        mem_addr = a;
        mem_wdata = d;
      end
      if (k == drop_k) begin
        mem_read = 0;
        mem_write = 0;
      end
      if (k == chg_k) mem_addr = a ^ 28'h10;
      @(negedge clk);
      if (rdy(s)) begin
        lat = k;
        data = rdat(s);
      end else if (rdat(s) !== '0) nz++;
      step();
      if (lat >= 0) break;
    end
    mem_read = 0;
    mem_write = 0;
  endtask

  task automatic test_reset();
    step();
    do_reset();
    total++;
    if ({ready0, err0, rdc0, wrc0, rdata0} !== '0) begin
      bad++;
      $display("FAIL reset_u0 got rdy=%b err=%b rd=%0d wr=%0d rdata=%h want all zero", ready0, err0, rdc0, wrc0, rdata0);
    end
    total++;
    if ({ready1, err1, rdc1, wrc1, rdata1} !== '0) begin
      bad++;
      $display("FAIL reset_u1 got rdy=%b err=%b rd=%0d wr=%0d want all zero", ready1, err1, rdc1, wrc1);
    end
  endtask

  task automatic test_read_latency();
    int lat, nz, quiet;
    logic [127:0] d;
    while (cyc < 10) step();
    do_req(0, 1, 0, 28'h50, '0, -1, -1, lat, d, nz);
    total++;
    if (10 + lat !== 18) begin
      bad++;
      $display("FAIL read_ready_cycle got %0d want 18", 10 + lat);
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL read_rdata_idle got %0d nonzero cycles want 0", nz);
    end
    total++;
    if (rdc0 !== 32'd1) begin
      bad++;
      $display("FAIL read_count got %0d want 1", rdc0);
    end
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready0 || rdata0 !== '0) quiet++;
      step();
    end
    total++;
    if (quiet !== 0) begin
      bad++;
      $display("FAIL read_after_quiet got %0d active cycles want 0", quiet);
    end
  endtask

  task automatic test_write_read();
    int lat, nz;
    logic [127:0] d;
    do_reset();
    do_req(0, 0, 1, 28'h40, D_BEEF, -1, -1, lat, d, nz);
    total++;
    if (lat !== 8 || d !== '0) begin
      bad++;
      $display("FAIL write_resp got lat=%0d rdata=%h want lat=8 rdata=0", lat, d);
    end
    do_req(0, 1, 0, 28'h40, '0, -1, -1, lat, d, nz);
    total++;
    if (d !== D_BEEF) begin
      bad++;
      $display("FAIL write_read_data got %h want %h", d, D_BEEF);
    end
    total++;
    if (wrc0 !== 32'd1 || rdc0 !== 32'd1) begin
      bad++;
      $display("FAIL write_read_counts got wr=%0d rd=%0d want wr=1 rd=1", wrc0, rdc0);
    end
  endtask

  task automatic test_back_to_back();
    int la, lb, nz, c0, c1;
    logic [127:0] d;
    do_req(0, 0, 1, 28'h70, E7, -1, -1, la, d, nz);
    c0 = cyc;
    do_req(0, 0, 1, 28'h30, E3, -1, -1, la, d, nz);
    c1 = cyc;
    do_req(0, 1, 0, 28'h70, '0, -1, -1, lb, d, nz);
    total++;
    if (la !== 8 || lb !== 8) begin
      bad++;
      $display("FAIL b2b_latency got %0d/%0d want 8/8", la, lb);
    end
    total++;
    if ((c1 + lb) - (c0 + la) !== 9) begin
      bad++;
      $display("FAIL b2b_pulse_gap got %0d want 9", (c1 + lb) - (c0 + la));
    end
    total++;
    if (d !== E7) begin
      bad++;
      $display("FAIL b2b_refill_data got %h want %h", d, E7);
    end
    do_req(0, 1, 0, 28'h30, '0, -1, -1, lb, d, nz);
    total++;
    if (d !== E3) begin
      bad++;
      $display("FAIL b2b_writeback_data got %h want %h", d, E3);
    end
    total++;
    if (wrc0 !== 32'd3 || rdc0 !== 32'd3) begin
      bad++;
      $display("FAIL b2b_counts got wr=%0d rd=%0d want wr=3 rd=3", wrc0, rdc0);
    end
  endtask

  task automatic test_drop();
    int lat, nz;
    logic [127:0] d;
    do_req(0, 0, 1, 28'h90, VA, -1, -1, lat, d, nz);
    do_req(0, 0, 1, 28'h90, VB, 3, -1, lat, d, nz);
    total++;
    if (lat !== -1 || nz !== 0) begin
      bad++;
      $display("FAIL drop_no_ready got lat=%0d nz=%0d want lat=-1 nz=0", lat, nz);
    end
    total++;
    if (wrc0 !== 32'd4 || rdc0 !== 32'd3 || err0 !== 1'b0) begin
      bad++;
      $display("FAIL drop_state got wr=%0d rd=%0d err=%b want wr=4 rd=3 err=0", wrc0, rdc0, err0);
    end
    do_req(0, 1, 0, 28'h90, '0, -1, -1, lat, d, nz);
    total++;
    if (d !== VA) begin
      bad++;
      $display("FAIL drop_old_data got %h want %h", d, VA);
    end
  endtask

  task automatic test_protocol();
    int lat, nz;
    logic [127:0] d;
    do_reset();
    do_req(0, 1, 1, 28'hA0, VF, -1, -1, lat, d, nz);
    total++;
    if (lat !== 8 || d !== '0 || err0 !== 1'b1 || wrc0 !== 32'd1 || rdc0 !== 32'd0) begin
      bad++;
      $display("FAIL both_as_write got lat=%0d rdata=%h err=%b wr=%0d rd=%0d want 8/0/1/1/0", lat, d, err0, wrc0, rdc0);
    end
    do_req(0, 1, 0, 28'hA0, '0, -1, -1, lat, d, nz);
    total++;
    if (d !== VF || err0 !== 1'b1) begin
      bad++;
      $display("FAIL both_sticky got rdata=%h err=%b want %h err=1", d, err0, VF);
    end
    do_reset();
    total++;
    if (err0 !== 1'b0) begin
      bad++;
      $display("FAIL err_cleared got %b want 0", err0);
    end
    do_req(0, 1, 0, 28'h40, '0, -1, 2, lat, d, nz);
    total++;
    if (lat !== 8 || d !== D_BEEF || err0 !== 1'b1) begin
      bad++;
      $display("FAIL addr_change got lat=%0d rdata=%h err=%b want 8 %h err=1", lat, d, err0, D_BEEF);
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat, nz, act;
    logic [127:0] d;
    do_reset();
    mem_write = 1;
    mem_addr = 28'h90;
    mem_wdata = VB;
    for (int i = 0; i < 4; i++) step();
    proc_reset = 1;
    mem_write = 0;
    step();
    proc_reset = 0;
    total++;
    if ({ready0, err0, rdc0, wrc0, rdata0} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got rdy=%b err=%b rd=%0d wr=%0d want all zero", ready0, err0, rdc0, wrc0);
    end
    act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0) act++;
      step();
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL mid_reset_no_ready got %0d pulses want 0", act);
    end
    do_req(0, 1, 0, 28'h90, '0, -1, -1, lat, d, nz);
    total++;
    if (d !== VA || rdc0 !== 32'd1 || wrc0 !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_line got %h rd=%0d wr=%0d want %h rd=1 wr=0", d, rdc0, wrc0, VA);
    end
  endtask

  task automatic test_latency_one();
    int lat, nz;
    logic [127:0] d;
    do_reset();
    do_req(1, 0, 1, 28'h20, VG, -1, -1, lat, d, nz);
    total++;
    if (lat !== 1) begin
      bad++;
      $display("FAIL lat1_write got %0d want 1", lat);
    end
    do_req(1, 1, 0, 28'h20, '0, -1, -1, lat, d, nz);
    total++;
    if (lat !== 1 || d !== VG || rdc1 !== 32'd1 || wrc1 !== 32'd1) begin
      bad++;
      $display("FAIL lat1_read got lat=%0d rdata=%h rd=%0d wr=%0d want 1 %h 1 1", lat, d, rdc1, wrc1, VG);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_back_to_back();
    test_drop();
    test_protocol();
    test_reset_mid_wait();
    test_latency_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slow_mem_responder.md
Name: slow_mem_responder

Overview:
- Cycle-accurate responder for the cache-to-slow-memory line interface (mem_read / mem_write / mem_addr[31:4] / 128-bit data / mem_ready).
- One instance sits behind each of the D- and I-cache memory ports. It replaces the behavioural slow memory in synthesizable and formal benches.
- Holds a line-wide storage array and answers each request after a fixed, programmable latency with a one-cycle mem_ready pulse.
- Keeps completion counters and a sticky protocol-error flag for verification.

Parameters:
- LATENCY, 8, cycles from request acceptance to mem_ready; legal range 1..255.
- IDX_W, 10, line-index width; the array holds 2^IDX_W lines of 128 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- proc_reset  input  1  synchronous, active-high reset.
- mem_read  input  1  line read request from the cache; held until mem_ready.
- mem_write  input  1  line write request from the cache; held until mem_ready.
- mem_addr  input  28  line address [31:4]; index = mem_addr[IDX_W+3:4]; upper bits ignored.
- mem_wdata  input  128  write line.
- mem_rdata  output  128  read line; valid only while mem_ready is high.
- mem_ready  output  1  one-cycle completion pulse.
- rd_count  output  32  number of completed reads.
- wr_count  output  32  number of completed writes.
- protocol_err  output  1  sticky; set when a protocol violation is detected.

Behaviour:
- Reset (synchronous, proc_reset=1 at the edge):
  - state=IDLE.
  - mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, protocol_err=0.
  - The storage array is not cleared; it keeps its contents across reset.
  - Reset overrides everything, including a pending request, which is aborted without committing.
- IDLE:
  - If mem_read|mem_write is sampled high at an edge, the request is accepted.
  - Latched at acceptance: index, type (write if mem_write=1), mem_wdata.
  - Wait counter loaded with LATENCY-1; next state WAIT.
- Simultaneous mem_read=1 and mem_write=1 at acceptance:
  - Treated as a write.
  - protocol_err set to 1.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, the next state is RESP.
  - With LATENCY=1, the machine goes from acceptance straight to RESP.
- RESP (exactly one cycle):
  - mem_ready=1.
  - Read: mem_rdata = array[latched index].
  - Write: array[latched index] updated at the edge ending RESP.
  - The matching counter increments at that same edge.
  - Next state IDLE.
- Latency rule: if a request is first high in cycle t, mem_ready is high in cycle t+LATENCY and in no other cycle.
- mem_rdata returns to 0 in every cycle where mem_ready=0. On a write response, mem_rdata=0.
- Request dropped (mem_read=mem_write=0) while in WAIT:
  - Transaction aborted; state returns to IDLE next cycle.
  - No mem_ready pulse, no array update, no count increment.
  - protocol_err unchanged.
- Address, data or type changing during WAIT is ignored (latched values are used) and sets protocol_err.
- Back-to-back requests:
  - A request held high in the cycle immediately after RESP is accepted from IDLE in that cycle.
  - This gives a one-cycle minimum gap between ready pulses.
  - A read following a write to the same index returns the written data.
- Counters wrap modulo 2^32.
- Storage array is a plain register array with a single port, used once per transaction. No bypass is needed because the write commits before any later read can reach RESP.

Test Plan:
- Reset then read index 5 with LATENCY=8 (request high from cycle 10) -> mem_ready only in cycle 18; rd_count=1; mem_rdata=0 outside cycle 18.
- Write 128'hDEAD..BEEF to mem_addr=28'h0000040 (index 4), then read the same address -> the read returns 128'hDEAD..BEEF; wr_count=1, rd_count=1.
- Cache-style write-back then refill: write to index 3 held until ready, read of index 7 asserted the next cycle -> ready pulses exactly 8 cycles apart from each acceptance, minimum 1-cycle gap; both complete.
- Request dropped in WAIT cycle 3 -> no mem_ready; a following read of the same line returns the old data; counters unchanged.
- mem_read=mem_write=1 at acceptance -> handled as a write; protocol_err=1 and stays 1 until proc_reset.
- proc_reset asserted mid-WAIT of a write -> everything returns to reset values next cycle; array line unchanged. With LATENCY=1, a read shows ready in the cycle after the request appears.
